// File: rtl/dco_tune_seq_if.sv
// DCO tuning sequencer bus: run enable, error samples in, DCO controls and status out.
interface dco_tune_seq_if #(
    parameter int ERR_W = 12
);
    logic                    en;
    logic                    tune_vld;
    logic signed [ERR_W-1:0] tune_err;
    logic                    pd;
    logic [1:0]              osc_gain;
    logic [4:0]              c_l_rall;
    logic [4:0]              c_l_row;
    logic [4:0]              c_l_col;
    logic [15:0]             c_m_rall;
    logic [15:0]             c_m_row;
    logic [15:0]             c_m_col;
    logic [15:0]             c_s_rall;
    logic [15:0]             c_s_row;
    logic [15:0]             c_s_col;
    logic [1:0]              mode;
    logic                    lock;
    logic                    sat;

    modport master (
        output en, tune_vld, tune_err,
        input  pd, osc_gain, c_l_rall, c_l_row, c_l_col,
               c_m_rall, c_m_row, c_m_col, c_s_rall, c_s_row, c_s_col,
               mode, lock, sat
    );

    modport slave (
        input  en, tune_vld, tune_err,
        output pd, osc_gain, c_l_rall, c_l_row, c_l_col,
               c_m_rall, c_m_row, c_m_col, c_s_rall, c_s_row, c_s_col,
               mode, lock, sat
    );
endinterface

// File: rtl/dco_tune_seq.sv
// DCO power-up and cap-bank tuning sequencer: PVT -> ACQ -> TRK, one code
// register per bank, each decoded to the bank's rall/row/col controls.
module dco_tune_seq #(
    parameter int         ERR_W      = 12,
    parameter int         PD_CYC     = 16,
    parameter int         SETTLE_CYC = 32,
    parameter int         LOCK_THR   = 4,
    parameter int         L_INIT     = 12,
    parameter int         M_INIT     = 128,
    parameter int         S_INIT     = 128,
    parameter logic [1:0] OSC_GAIN   = 2'b10
) (
    input  logic           clk,
    input  logic           rst_n,
    dco_tune_seq_if.slave  bus
);
    localparam int PW    = $clog2(PD_CYC + 1);
    localparam int SW    = $clog2(SETTLE_CYC + 1);
    localparam int SUM_W = ERR_W + 2;

    localparam logic [4:0] L_INIT_C = 5'(L_INIT);
    localparam logic [7:0] M_INIT_C = 8'(M_INIT);
    localparam logic [7:0] S_INIT_C = 8'(S_INIT);
    localparam logic [4:0] L_MAX    = 5'd25;
    localparam logic [7:0] MS_MAX   = 8'd255;
    localparam logic signed [ERR_W-1:0] THR_P = ERR_W'(LOCK_THR);
    localparam logic signed [ERR_W-1:0] THR_N = ERR_W'(-LOCK_THR);
    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(255);

    typedef enum logic [2:0] {ST_OFF, ST_PD_WAIT, ST_PVT, ST_ACQ, ST_TRK} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pd_cnt_q, pd_cnt_d;
    logic [SW-1:0]   scnt_q, scnt_d;
    logic [4:0]      code_l_q, code_l_d;
    logic [7:0]      code_m_q, code_m_d;
    logic [7:0]      code_s_q, code_s_d;
    logic            pd_q, pd_d;
    logic [1:0]      osc_gain_q, osc_gain_d;
    logic [1:0]      mode_q, mode_d;
    logic            lock_q, lock_d;
    logic            sat_q, sat_d;

    logic                    in_thr;
    logic                    err_pos;
    logic signed [SUM_W-1:0] trk_sum;

    // Threshold test as a signed range check, so the most-negative error
    // falls outside without ever forming its (unrepresentable) magnitude.
    always_comb begin
        in_thr  = (bus.tune_err >= THR_N) && (bus.tune_err <= THR_P);
        err_pos = ~bus.tune_err[ERR_W-1];
        trk_sum = $signed({{(SUM_W-8){1'b0}}, code_s_q})
                + $signed({{2{bus.tune_err[ERR_W-1]}}, bus.tune_err});
    end

    // Next-state and next-output computation; en low returns everything to OFF.
    always_comb begin
        state_d  = state_q;
        pd_cnt_d = pd_cnt_q;
        scnt_d   = scnt_q;
        code_l_d = code_l_q;
        code_m_d = code_m_q;
        code_s_d = code_s_q;
        lock_d   = lock_q;
        sat_d    = sat_q;
        if (!bus.en) begin
            state_d  = ST_OFF;
            pd_cnt_d = '0;
            scnt_d   = '0;
            code_l_d = L_INIT_C;
            code_m_d = M_INIT_C;
            code_s_d = S_INIT_C;
            lock_d   = 1'b0;
            sat_d    = 1'b0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d  = ST_PD_WAIT;
                    pd_cnt_d = '0;
                end
                ST_PD_WAIT: begin
                    if (pd_cnt_q == PW'(PD_CYC - 1)) state_d = ST_PVT;
                    else pd_cnt_d = pd_cnt_q + 1'b1;
                end
                ST_PVT, ST_ACQ: begin
                    if (bus.tune_vld) begin
                        if (!in_thr) begin
                            scnt_d = '0;
                            if (state_q == ST_PVT) begin
                                if (err_pos) code_l_d = (code_l_q == L_MAX) ? L_MAX : code_l_q + 1'b1;
                                else         code_l_d = (code_l_q == 5'd0) ? 5'd0 : code_l_q - 1'b1;
                            end else begin
                                if (err_pos) code_m_d = (code_m_q == MS_MAX) ? MS_MAX : code_m_q + 1'b1;
                                else         code_m_d = (code_m_q == 8'd0) ? 8'd0 : code_m_q - 1'b1;
                            end
                        end else if (scnt_q == SW'(SETTLE_CYC - 1)) begin
                            scnt_d  = '0;
                            state_d = (state_q == ST_PVT) ? ST_ACQ : ST_TRK;
                        end else begin
                            scnt_d = scnt_q + 1'b1;
                        end
                    end
                end
                ST_TRK: begin
                    if (bus.tune_vld) begin
                        if (trk_sum < 0) begin
                            code_s_d = 8'd0;
                            sat_d    = 1'b1;
                        end else if (trk_sum > SUM_MAX) begin
                            code_s_d = MS_MAX;
                            sat_d    = 1'b1;
                        end else begin
                            code_s_d = trk_sum[7:0];
                            sat_d    = 1'b0;
                        end
                        if (!in_thr) scnt_d = '0;
                        else if (scnt_q != SW'(SETTLE_CYC)) scnt_d = scnt_q + 1'b1;
                        lock_d = (scnt_d == SW'(SETTLE_CYC));
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
        pd_d       = (state_d == ST_OFF);
        osc_gain_d = (state_d == ST_OFF) ? 2'b00 : OSC_GAIN;
        case (state_d)
            ST_PVT:  mode_d = 2'd1;
            ST_ACQ:  mode_d = 2'd2;
            ST_TRK:  mode_d = 2'd3;
            default: mode_d = 2'd0;
        endcase
    end

    // State, code and registered-output flops with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            pd_cnt_q   <= '0;
            scnt_q     <= '0;
            code_l_q   <= L_INIT_C;
            code_m_q   <= M_INIT_C;
            code_s_q   <= S_INIT_C;
            pd_q       <= 1'b1;
            osc_gain_q <= 2'b00;
            mode_q     <= 2'd0;
            lock_q     <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pd_cnt_q   <= pd_cnt_d;
            scnt_q     <= scnt_d;
            code_l_q   <= code_l_d;
            code_m_q   <= code_m_d;
            code_s_q   <= code_s_d;
            pd_q       <= pd_d;
            osc_gain_q <= osc_gain_d;
            mode_q     <= mode_d;
            lock_q     <= lock_d;
            sat_q      <= sat_d;
        end
    end

    logic [2:0]  q_l, r_l;
    logic [3:0]  q_m, r_m, q_s, r_s;
    logic [4:0]  l_rall, l_row, l_col;
    logic [15:0] m_rall, m_row, m_col, s_rall, s_row, s_col;

    // Thermometer/row/column decode: cap count equals the code for each bank.
    always_comb begin
        q_l = 3'(code_l_q / 5'd5);
        r_l = 3'(code_l_q % 5'd5);
        q_m = code_m_q[7:4];
        r_m = code_m_q[3:0];
        q_s = code_s_q[7:4];
        r_s = code_s_q[3:0];
        for (int i = 0; i < 5; i++) begin
            l_rall[i] = (3'(i) < q_l);
            l_row[i]  = (3'(i) == q_l);
            l_col[i]  = (3'(i) < r_l);
        end
        for (int i = 0; i < 16; i++) begin
            m_rall[i] = (4'(i) < q_m);
            m_row[i]  = (4'(i) == q_m);
            m_col[i]  = (4'(i) < r_m);
            s_rall[i] = (4'(i) < q_s);
            s_row[i]  = (4'(i) == q_s);
            s_col[i]  = (4'(i) < r_s);
        end
    end

    assign bus.pd       = pd_q;
    assign bus.osc_gain = osc_gain_q;
    assign bus.mode     = mode_q;
    assign bus.lock     = lock_q;
    assign bus.sat      = sat_q;
    assign bus.c_l_rall = l_rall;
    assign bus.c_l_row  = l_row;
    assign bus.c_l_col  = l_col;
    assign bus.c_m_rall = m_rall;
    assign bus.c_m_row  = m_row;
    assign bus.c_m_col  = m_col;
    assign bus.c_s_rall = s_rall;
    assign bus.c_s_row  = s_row;
    assign bus.c_s_col  = s_col;
endmodule
